mem_arbiter_rr: RTL and testbench

//   N-channel arbiter for the req/ready memory interface used by cpu_multicycle, imem_sync and dmem_sync.

---
 rtl/mem_arbiter_rr.sv | 113 +++++++++++
 tb/tb_mem_arbiter_rr.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_rr.sv
// Merges NUM_CH req/ready requesters onto one memory port (round-robin or fixed priority); grant attributes are latched.
// Latency: ch_req->mem_req 1 cycle, mem_ready->ch_ready 0 cycles; requests stall by holding ch_req until their ch_ready.
module mem_arbiter_rr #(
  parameter int NUM_CH        = 3,
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  input  logic [NUM_CH-1:0]        ch_we,
  input  logic [NUM_CH*3-1:0]      ch_mode,
  output logic [NUM_CH-1:0]        ch_ready,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_we,
  output logic [2:0]               mem_mode,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_ready
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PTR_W-1:0] r_rr_ptr;
  logic [PTR_W-1:0] r_grant;
  logic [PTR_W-1:0] w_winner;
  logic [PTR_W-1:0] w_cand;
  logic             w_found;
  logic             w_done;

  function automatic logic [PTR_W-1:0] wrap_idx(input int base, input int ofs);
    int s;
    s = base + ofs;
    if (s >= NUM_CH) s = s - NUM_CH;
    return PTR_W'(s);
  endfunction

  // Search upward from the pointer (RR) or from channel 0 (fixed), first requester wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_cand = (PRIORITY_MODE != 0) ? PTR_W'(k) : wrap_idx(int'(r_rr_ptr), k);
      if (!w_found && ch_req[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_BUSY;
      S_BUSY:  if (mem_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  assign mem_req = (r_state == S_BUSY);
  assign w_done  = (r_state == S_BUSY) && mem_ready && !rst;

  always_comb begin
    ch_ready = '0;
    ch_rdata = '0;
    if (w_done) begin
      ch_ready[r_grant] = 1'b1;
      ch_rdata          = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr  <= '0;
      r_grant   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_mode  <= 3'b000;
    end else begin
      if (r_state == S_IDLE && w_found) begin
        r_grant   <= w_winner;
        mem_addr  <= ch_addr[int'(w_winner)*ADDR_W +: ADDR_W];
        mem_wdata <= ch_wdata[int'(w_winner)*DATA_W +: DATA_W];
        mem_we    <= ch_we[w_winner];
        mem_mode  <= ch_mode[int'(w_winner)*3 +: 3];
      end
      // Explicit wrap so non-power-of-two channel counts never point past NUM_CH-1.
      if (w_done) begin
        r_rr_ptr <= (r_grant == PTR_W'(NUM_CH-1)) ? '0 : r_grant + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Scoreboard bench for mem_arbiter_rr: one round-robin and one fixed-priority instance share stimulus and a memory model.
module tb_mem_arbiter_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [31:0] addr_v  [3];
  logic [31:0] wdata_v [3];
  logic [2:0]  we_v = 3'b000;
  logic [2:0]  mode_v  [3];

  logic [95:0] ch_addr_bus, ch_wdata_bus;
  logic [8:0]  ch_mode_bus;
  assign ch_addr_bus  = {addr_v[2], addr_v[1], addr_v[0]};
  assign ch_wdata_bus = {wdata_v[2], wdata_v[1], wdata_v[0]};
  assign ch_mode_bus  = {mode_v[2], mode_v[1], mode_v[0]};

  logic        model_rdy = 1'b0;
  logic        force_rdy = 1'b0;
  logic        mem_ready;
  logic [31:0] mem_rdata = '0;
  assign mem_ready = model_rdy | force_rdy;

  logic [2:0]  rr_req, fp_req;
  logic        rr_mready, fp_mready;
  assign rr_req    = sel ? 3'b000 : req;
  assign fp_req    = sel ? req : 3'b000;
  assign rr_mready = sel ? 1'b0 : mem_ready;
  assign fp_mready = sel ? mem_ready : 1'b0;

  logic [2:0]  rr_ch_ready, fp_ch_ready;
  logic [31:0] rr_ch_rdata, fp_ch_rdata;
  logic        rr_mem_req, fp_mem_req;
  logic [31:0] rr_mem_addr, fp_mem_addr, rr_mem_wdata, fp_mem_wdata;
  logic        rr_mem_we, fp_mem_we;
  logic [2:0]  rr_mem_mode, fp_mem_mode;

  mem_arbiter_rr #(.NUM_CH(3), .ADDR_W(32), .DATA_W(32), .PRIORITY_MODE(0)) dut_rr (
    .clk(clk), .rst(rst), .ch_req(rr_req), .ch_addr(ch_addr_bus), .ch_wdata(ch_wdata_bus),
    .ch_we(we_v), .ch_mode(ch_mode_bus), .ch_ready(rr_ch_ready), .ch_rdata(rr_ch_rdata),
    .mem_req(rr_mem_req), .mem_addr(rr_mem_addr), .mem_wdata(rr_mem_wdata), .mem_we(rr_mem_we),
    .mem_mode(rr_mem_mode), .mem_rdata(mem_rdata), .mem_ready(rr_mready)
  );

  mem_arbiter_rr #(.NUM_CH(3), .ADDR_W(32), .DATA_W(32), .PRIORITY_MODE(1)) dut_fp (
    .clk(clk), .rst(rst), .ch_req(fp_req), .ch_addr(ch_addr_bus), .ch_wdata(ch_wdata_bus),
    .ch_we(we_v), .ch_mode(ch_mode_bus), .ch_ready(fp_ch_ready), .ch_rdata(fp_ch_rdata),
    .mem_req(fp_mem_req), .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_we(fp_mem_we),
    .mem_mode(fp_mem_mode), .mem_rdata(mem_rdata), .mem_ready(fp_mready)
  );

  logic [2:0]  a_ready, a_mode;
  logic [31:0] a_rdata, a_addr, a_wdata;
  logic        a_req, a_we;
  assign a_ready = sel ? fp_ch_ready  : rr_ch_ready;
  assign a_rdata = sel ? fp_ch_rdata  : rr_ch_rdata;
  assign a_req   = sel ? fp_mem_req   : rr_mem_req;
  assign a_addr  = sel ? fp_mem_addr  : rr_mem_addr;
  assign a_wdata = sel ? fp_mem_wdata : rr_mem_wdata;
  assign a_we    = sel ? fp_mem_we    : rr_mem_we;
  assign a_mode  = sel ? fp_mem_mode  : rr_mem_mode;

  int checks = 0;
  int errors = 0;
  int n_pops = 0;
  int exp_pops = 0;

  typedef struct packed {
    logic [2:0]  rdy;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [2:0]  mode;
    logic [31:0] rdata;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Memory model: ready is raised in the lat-th cycle of a request, for one cycle.
  int          lat = 1;
  int          cnt = 0;
  bit          auto_en = 1'b1;
  logic [31:0] mdata = '0;
  always @(posedge clk) begin
    #1;
    if (!auto_en || model_rdy) begin
      model_rdy = 1'b0;
      cnt = 0;
    end else if (a_req) begin
      cnt++;
      if (cnt >= lat) begin
        model_rdy = 1'b1;
        mem_rdata = mdata;
      end
    end else begin
      cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (a_ready !== 3'b000) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready actual=%b required=none", a_ready);
      end else begin
        mon_e = q.pop_front();
        chk("sb_ch_ready", {29'd0, a_ready}, {29'd0, mon_e.rdy});
        chk("sb_mem_addr", a_addr, mon_e.addr);
        chk("sb_mem_wdata", a_wdata, mon_e.wdata);
        chk("sb_mem_we", {31'd0, a_we}, {31'd0, mon_e.we});
        chk("sb_mem_mode", {29'd0, a_mode}, {29'd0, mon_e.mode});
        chk("sb_ch_rdata", a_rdata, mon_e.rdata);
        n_pops++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input int ch, input logic [31:0] rd);
    exp_t e;
    e.rdy   = 3'b001 << ch;
    e.addr  = addr_v[ch];
    e.wdata = wdata_v[ch];
    e.we    = we_v[ch];
    e.mode  = mode_v[ch];
    e.rdata = rd;
    q.push_back(e);
    exp_pops++;
  endtask

  task automatic wait_pops(input int target);
    for (int k = 0; k < 300; k++) begin
      if (n_pops >= target) break;
      tick();
    end
    chk("pop_count", n_pops, target);
  endtask

  task automatic set_defaults();
    for (int i = 0; i < 3; i++) begin
      addr_v[i]  = 32'h1000 + 32'(16 * i);
      wdata_v[i] = 32'hC0DE_0000 + 32'(i);
      mode_v[i]  = 3'b010;
    end
    we_v = 3'b000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_mem_req", {31'd0, a_req}, 32'd0);
    chk("rst_mem_addr", a_addr, 32'd0);
    chk("rst_mem_we", {31'd0, a_we}, 32'd0);
    chk("rst_mem_mode", {29'd0, a_mode}, 32'd0);
    chk("rst_ch_ready", {29'd0, a_ready}, 32'd0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    set_defaults();

    // T1 single read on channel 1
    do_reset();
    addr_v[1] = 32'h100;
    lat = 2;
    mdata = 32'hDEAD_BEEF;
    push_exp(1, 32'hDEAD_BEEF);
    req = 3'b010;
    @(negedge clk);
    chk("t1_idle_mem_req", {31'd0, a_req}, 32'd0);
    tick();
    @(negedge clk);
    chk("t1_mem_req", {31'd0, a_req}, 32'd1);
    chk("t1_mem_addr", a_addr, 32'h100);
    wait_pops(exp_pops);
    req = 3'b000;
    set_defaults();

    // T2 round-robin fairness, all channels requesting
    do_reset();
    lat = 1;
    mdata = 32'h0000_5A5A;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++) push_exp(c, 32'h0000_5A5A);
    req = 3'b111;
    wait_pops(exp_pops);
    req = 3'b000;
    repeat (3) tick();
    chk("t2_no_extra", n_pops, exp_pops);

    // T3 fixed priority: ch0 wins six times, ch2 only after ch0 drops
    sel = 1'b1;
    do_reset();
    mdata = 32'h0000_0033;
    for (int r = 0; r < 6; r++) push_exp(0, 32'h0000_0033);
    push_exp(2, 32'h0000_0033);
    req = 3'b101;
    wait_pops(exp_pops - 1);
    req = 3'b100;
    wait_pops(exp_pops);
    req = 3'b000;
    tick();
    sel = 1'b0;

    // T4 attributes latched at grant despite later changes
    do_reset();
    lat = 4;
    mdata = 32'h0000_4444;
    addr_v[2] = 32'h40;
    wdata_v[2] = 32'h1234_5678;
    we_v[2] = 1'b1;
    mode_v[2] = 3'b000;
    push_exp(2, 32'h0000_4444);
    req = 3'b100;
    tick();
    tick();
    addr_v[2] = 32'h80;
    wdata_v[2] = 32'hFFFF_FFFF;
    we_v[2] = 1'b0;
    mode_v[2] = 3'b111;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("t4_mem_addr", a_addr, 32'h40);
      chk("t4_mem_wdata", a_wdata, 32'h1234_5678);
      chk("t4_mem_we", {31'd0, a_we}, 32'd1);
      chk("t4_mem_mode", {29'd0, a_mode}, 32'd0);
      tick();
    end
    wait_pops(exp_pops);
    req = 3'b000;
    set_defaults();

    // T5 slow memory: four stable cycles, one ready pulse, then mem_req low
    do_reset();
    lat = 5;
    mdata = 32'h0000_5555;
    push_exp(0, 32'h0000_5555);
    req = 3'b001;
    tick();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t5_mem_req", {31'd0, a_req}, 32'd1);
      chk("t5_ch_ready", {29'd0, a_ready}, 32'd0);
      chk("t5_mem_addr", a_addr, 32'h1000);
      tick();
    end
    wait_pops(exp_pops);
    req = 3'b000;
    @(negedge clk);
    chk("t5_mem_req_after", {31'd0, a_req}, 32'd0);

    // T6 reset mid-transaction: pointer returns to 0, late ready ignored
    do_reset();
    lat = 1;
    mdata = 32'h0000_0066;
    push_exp(1, 32'h0000_0066);
    req = 3'b010;
    wait_pops(exp_pops);
    req = 3'b000;
    tick();
    auto_en = 1'b0;
    req = 3'b100;
    tick();
    @(negedge clk);
    chk("t6_busy", {31'd0, a_req}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 3'b000;
    @(negedge clk);
    chk("t6_mem_req_rst", {31'd0, a_req}, 32'd0);
    chk("t6_mem_addr_rst", a_addr, 32'd0);
    tick();
    force_rdy = 1'b1;
    @(negedge clk);
    chk("t6_late_ready", {29'd0, a_ready}, 32'd0);
    tick();
    force_rdy = 1'b0;
    @(negedge clk);
    chk("t6_still_idle", {31'd0, a_req}, 32'd0);
    tick();
    auto_en = 1'b1;
    mdata = 32'h0000_0077;
    push_exp(0, 32'h0000_0077);
    req = 3'b111;
    wait_pops(exp_pops);
    req = 3'b000;

    repeat (5) tick();
    chk("queue_empty", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
